// File: rtl/pir_report_tx_if.sv
// ----------------------------------------------------------------------------
// pir_report_tx_if
//   Display/status bus between the PIR motion controller (writer) and the
//   serial report transmitter (reader).
//
//   Signals
//     display_threshold        8  max-average value
//     display_from_threshold   4  sensor index of threshold
//     display_last_measurment  8  last triggering average
//     display_from_measurment  4  sensor index of last measurement
//     display_total_sensors    8  accumulated trigger count
//     display_average_1/_2/_3  8  per-sensor averages
//     LED                      3  sensor trigger LEDs
//
//   Modports
//     master : motion controller side, drives the display registers
//     slave  : report transmitter side, samples the display registers
// ----------------------------------------------------------------------------
interface pir_report_tx_if;
   logic [7:0] display_threshold;
   logic [3:0] display_from_threshold;
   logic [7:0] display_last_measurment;
   logic [3:0] display_from_measurment;
   logic [7:0] display_total_sensors;
   logic [7:0] display_average_1;
   logic [7:0] display_average_2;
   logic [7:0] display_average_3;
   logic [2:0] LED;

   modport master (
      output display_threshold, display_from_threshold,
             display_last_measurment, display_from_measurment,
             display_total_sensors, display_average_1,
             display_average_2, display_average_3, LED
   );

   modport slave (
      input  display_threshold, display_from_threshold,
             display_last_measurment, display_from_measurment,
             display_total_sensors, display_average_1,
             display_average_2, display_average_3, LED
   );
endinterface

// File: rtl/pir_report_tx.sv
// ----------------------------------------------------------------------------
// pir_report_tx
//   Snapshots the PIR controller's display registers and sends them as a
//   10-byte frame on a UART-style line (8N1, LSB first, idle high):
//     A5 | thr | {from_thr,from_meas} | last | total | avg1 | avg2 | avg3 |
//     {5'b0,LED} | XOR(B1..B8)
//   A frame is triggered every PERIOD cycles and on every alarm rising edge.
//   A trigger arriving while a frame is in flight is queued (one deep).
//
//   Build option
//     PIR_REPORT_PARITY_EN : insert an even-parity bit after data bit 7
//                            (8E1, 11 bits per byte).
//
//   Ports
//     clk          in   system clock, rising edge
//     rst_n        in   synchronous active-low reset
//     enable       in   1 = reporting active
//     alarm        in   buzzer; rising edge forces a report
//     disp         in   display bus (pir_report_tx_if.slave)
//     tx           out  serial line, idle high
//     busy         out  high while a frame is being sent
//     frame_done   out  one-cycle pulse after the last stop bit
//     frames_sent  out  completed-frame count, wraps 255->0
// ----------------------------------------------------------------------------
module pir_report_tx #(
   parameter int          CLKS_PER_BIT = 16,
   parameter int          PERIOD       = 2000,
   parameter logic [7:0]  HEADER       = 8'hA5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  alarm,
   pir_report_tx_if.slave        disp,
   output logic                  tx,
   output logic                  busy,
   output logic                  frame_done,
   output logic [7:0]            frames_sent
);

   localparam int         CNT_W     = $clog2(CLKS_PER_BIT);
   localparam int         PER_W     = $clog2(PERIOD);
   localparam logic [3:0] LAST_BYTE = 4'd9;

`ifdef PIR_REPORT_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t            state;
   state_t            state_next;

   logic [PER_W-1:0]  period_cnt;
   logic              alarm_q;
   logic              pending;
   logic [CNT_W-1:0]  clk_cnt;
   logic [2:0]        bit_idx;
   logic [3:0]        byte_idx;
   logic              finishing;
   logic [7:0]        buffer [10];

   logic [7:0]        snap [10];
   logic [7:0]        checksum;
   logic [7:0]        cur_byte;
   logic              tick;
   logic              alarm_edge;
   logic              trigger;
   logic              bit_done;
   logic              tx_d;
   logic              busy_d;
   logic              done_d;

   // ------------------------------------------------------------------------
   // Trigger generation
   // ------------------------------------------------------------------------
   assign tick       = enable && (period_cnt == PER_W'(PERIOD - 1));
   assign alarm_edge = enable && alarm && !alarm_q;
   // A tick and an alarm edge in the same cycle collapse into one trigger.
   assign trigger    = tick || alarm_edge;

   assign bit_done   = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
   assign cur_byte   = buffer[byte_idx];

   // ------------------------------------------------------------------------
   // Frame image built from the live display bus; captured in LOAD
   // ------------------------------------------------------------------------
   assign checksum = disp.display_threshold
                   ^ {disp.display_from_threshold, disp.display_from_measurment}
                   ^ disp.display_last_measurment
                   ^ disp.display_total_sensors
                   ^ disp.display_average_1
                   ^ disp.display_average_2
                   ^ disp.display_average_3
                   ^ {5'b0, disp.LED};

   always_comb begin
      snap[0] = HEADER;
      snap[1] = disp.display_threshold;
      snap[2] = {disp.display_from_threshold, disp.display_from_measurment};
      snap[3] = disp.display_last_measurment;
      snap[4] = disp.display_total_sensors;
      snap[5] = disp.display_average_1;
      snap[6] = disp.display_average_2;
      snap[7] = disp.display_average_3;
      snap[8] = {5'b0, disp.LED};
      snap[9] = checksum;
   end

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values that existed before the clock edge.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_next;
   end

   // ------------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      // NOTE: default first, so no path leaves state_next unassigned and no
      // latch is inferred.
      state_next = state;
      unique case (state)
         S_IDLE:  if (trigger || (pending && enable)) state_next = S_LOAD;
         S_LOAD:  state_next = S_START;
         S_START: if (bit_done) state_next = S_DATA;
         S_DATA:  if (bit_done && bit_idx == 3'd7) begin
`ifdef PIR_REPORT_PARITY_EN
                     state_next = S_PARITY;
`else
                     state_next = S_STOP;
`endif
                  end
`ifdef PIR_REPORT_PARITY_EN
         S_PARITY: if (bit_done) state_next = S_STOP;
`endif
         S_STOP:  if (bit_done) state_next = (byte_idx == LAST_BYTE) ? S_IDLE : S_START;
         default: state_next = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: output logic (registered below so tx/busy/frame_done are glitch-free)
   // ------------------------------------------------------------------------
   always_comb begin
      tx_d   = 1'b1;
      busy_d = (state != S_IDLE);
      done_d = finishing;
      unique case (state)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = cur_byte[bit_idx];
`ifdef PIR_REPORT_PARITY_EN
         S_PARITY: tx_d = ^cur_byte;
`endif
         default:  tx_d = 1'b1;
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath: period counter, alarm history, pending flag, bit timing
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         period_cnt <= '0;
         alarm_q    <= 1'b0;
         pending    <= 1'b0;
         clk_cnt    <= '0;
         bit_idx    <= '0;
         byte_idx   <= '0;
         finishing  <= 1'b0;
      end else begin
         alarm_q <= alarm;

         if (!enable)       period_cnt <= '0;
         else if (tick)     period_cnt <= '0;
         else               period_cnt <= period_cnt + PER_W'(1);

         // IDLE always consumes the queued request; disabling drops it.
         if (!enable)                 pending <= 1'b0;
         else if (state == S_IDLE)    pending <= 1'b0;
         else if (trigger)            pending <= 1'b1;

         if (state == S_IDLE || state == S_LOAD) clk_cnt <= '0;
         else if (bit_done)                      clk_cnt <= '0;
         else                                    clk_cnt <= clk_cnt + CNT_W'(1);

         if (state == S_START)                bit_idx <= '0;
         else if (state == S_DATA && bit_done) bit_idx <= bit_idx + 3'd1;

         if (state == S_LOAD)                  byte_idx <= '0;
         else if (state == S_STOP && bit_done) byte_idx <= (byte_idx == LAST_BYTE) ? 4'd0 : byte_idx + 4'd1;

         finishing <= (state == S_STOP) && bit_done && (byte_idx == LAST_BYTE);
      end
   end

   // NOTE: the snapshot buffer is not reset; LOAD always rewrites every entry
   // before the first byte is read.
   always_ff @(posedge clk) begin
      if (state == S_LOAD) begin
         for (int i = 0; i < 10; i++) buffer[i] <= snap[i];
      end
   end

   // ------------------------------------------------------------------------
   // Output registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tx          <= 1'b1;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         frames_sent <= '0;
      end else begin
         tx         <= tx_d;
         busy       <= busy_d;
         frame_done <= done_d;
         if (done_d) frames_sent <= frames_sent + 8'd1;
      end
   end

endmodule
